// File: rtl/button_chord_scanner.sv
// ---------------------------------------------------------------------------
// button_chord_scanner
//
// Front end for the button encoder. Four raw active-low push-buttons are
// synchronised and debounced. While any key is held, the pressed keys are
// collected into a chord. When every key has been released, the chord is
// emitted on `buttons` as a single-cycle code in the range 1..15. Outside
// that one cycle, `buttons` is 0, so each gesture is acted on exactly once.
// A chord that is held longer than HOLD_CYCLES is abandoned. No code is
// emitted until all keys have been released.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable samples needed to accept a key change
//   HOLD_CYCLES     : maximum chord duration before the chord is abandoned
//
// Ports
//   clk_48   in   1 : system clock (the only clock in the block)
//   reset_n  in   1 : asynchronous active-low reset
//   key_n    in   4 : raw push-buttons, active-low, asynchronous to clk_48
//   buttons  out  4 : chord code, one-cycle pulse, 0 when idle
//   busy     out  1 : high while a chord is in progress or a release is awaited
// ---------------------------------------------------------------------------
module button_chord_scanner #(
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int HOLD_CYCLES     = 96000000
) (
    input  logic       clk_48,
    input  logic       reset_n,
    input  logic [3:0] key_n,
    output logic [3:0] buttons,
    output logic       busy
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CHORD        = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser. Both stages reset to "released", so a key that
    // is held through reset is seen as a new press once reset is released.
    // -----------------------------------------------------------------------
    logic [3:0] sync_1;
    logic [3:0] sync_2;
    logic [3:0] s;

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values that were present before the clock edge.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 4'hF;
            sync_2 <= 4'hF;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
        end
    end

    assign s = ~sync_2;

    // -----------------------------------------------------------------------
    // Per-key debounce. The counter only advances while the synchronised
    // level disagrees with the accepted level. Any agreement clears it, so
    // only an uninterrupted run of DEBOUNCE_CYCLES mismatches flips db.
    // -----------------------------------------------------------------------
    logic [3:0]            db;
    logic [3:0][DB_W-1:0]  db_cnt;

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            db     <= '0;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= s[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Chord FSM: state register
    // -----------------------------------------------------------------------
    state_t              state, state_next;
    logic [3:0]          chord, chord_next;
    logic [HOLD_W-1:0]   hold_cnt, hold_next;
    logic [3:0]          buttons_next;

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            chord    <= '0;
            hold_cnt <= '0;
            buttons  <= '0;
        end else begin
            state    <= state_next;
            chord    <= chord_next;
            hold_cnt <= hold_next;
            buttons  <= buttons_next;
        end
    end

    // -----------------------------------------------------------------------
    // Chord FSM: next state and outputs
    // -----------------------------------------------------------------------
    // NOTE: every signal is given a default before the case statement. This
    // keeps each path fully assigned, so no latch is inferred.
    always_comb begin
        state_next   = state;
        chord_next   = chord;
        hold_next    = hold_cnt;
        buttons_next = '0;

        unique case (state)
            IDLE: begin
                if (db != 4'd0) begin
                    chord_next = db;
                    hold_next  = '0;
                    state_next = CHORD;
                end
            end

            CHORD: begin
                // Keys pressed later join the chord. Keys released early
                // stay in it.
                chord_next = chord | db;
                // Release is tested first, so it wins over a timeout that
                // falls on the same edge.
                if (db == 4'd0) begin
                    buttons_next = chord;
                    chord_next   = '0;
                    state_next   = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    chord_next = '0;
                    state_next = WAIT_RELEASE;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end

            WAIT_RELEASE: begin
                // Presses are ignored here until all keys are released.
                if (db == 4'd0) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                chord_next = '0;
                hold_next  = '0;
            end
        endcase
    end

    assign busy = (state == CHORD) || (state == WAIT_RELEASE);

endmodule

// File: doc/button_chord_scanner.md
# button_chord_scanner

Front-end stage for the button encoder. It samples the four raw active-low push-buttons and synchronises each one. It then debounces each key, and accumulates a chord while any key is held. When every key is released it emits the chord as a 4-bit code for exactly one cycle. That code drives the encoder's `buttons` input, which holds 0 at all other times, so each completed gesture is acted on once (e.g. code 7 toggles mute once).

## Interface
- `DEBOUNCE_CYCLES`, default 480000: consecutive stable samples required to accept a key change (10 ms at 48 MHz).
- `HOLD_CYCLES`, default 96000000: maximum chord duration before the chord is abandoned (2 s at 48 MHz).
- `clk_48  in  1`: system clock; the block uses this one clock only.
- `reset_n  in  1`: asynchronous, active-low reset.
- `key_n  in  4`: raw push-buttons, active-low, asynchronous to `clk_48`.
- `buttons  out  4`: chord code; a one-cycle pulse, 0 when idle.
- `busy  out  1`: high while a chord is in progress or a release is awaited.

## Operation
- **Synchroniser:** two flops per bit. Both stages reset to 1 (released). The synchronised, inverted value is `s[i]` (1 = pressed).
- **Debounce (per key):**
  - State is `db[i]`, reset 0, plus a counter sized for `DEBOUNCE_CYCLES-1`, reset 0.
  - Each edge where `s[i] != db[i]`: if the counter equals `DEBOUNCE_CYCLES-1`, set `db[i] <= s[i]` and clear the counter; otherwise increment it.
  - Each edge where `s[i] == db[i]`: clear the counter.
  - Any mismatch run shorter than `DEBOUNCE_CYCLES` changes nothing.
- **FSM states:** IDLE, CHORD, WAIT_RELEASE. The FSM also holds a 4-bit `chord` register and a hold counter sized for `HOLD_CYCLES-1`. Reset values: state IDLE, `chord` 0, hold counter 0.
- **IDLE:**
  - `buttons <= 0`.
  - If `db != 0`: `chord <= db`, clear the hold counter, go to CHORD.
- **CHORD:**
  - `chord <= chord | db`. Keys added at any time join the chord; keys released early stay in it.
  - If `db == 0`: `buttons <= chord`, `chord <= 0`, go to IDLE.
  - Else if the hold counter equals `HOLD_CYCLES-1`: `chord <= 0`, go to WAIT_RELEASE, emit nothing.
  - Else increment the hold counter.
- **WAIT_RELEASE:**
  - `buttons` stays 0.
  - If `db == 0`: go to IDLE, emit nothing.
  - New presses during this state are ignored until all keys are released.
- **`busy`:** decoded from the state register, high in CHORD or WAIT_RELEASE.
- **`buttons`:** registered; it returns to 0 on the edge after a pulse.
- **Code range:** a chord is never 0, so every emitted code is 1..15.
- **Priority:** release beats timeout on the same edge, and the chord is emitted.
- **Reset mid-operation:** all state clears immediately, with no pulse.
  - Keys still physically held after reset are seen as released by the synchroniser.
  - They are then debounced as new presses and form a new chord.

## Timing
- Reset values: `buttons` = 0, `busy` = 0.
- A `key_n` change sampled at edge 0 reaches `s` after edge 1. `db` changes at edge `1+DEBOUNCE_CYCLES`, provided `s` holds the new value throughout.
- IDLE to CHORD: on the edge after `db` becomes nonzero, `busy` rises.
- Emit: `buttons` is valid for the single cycle following the edge on which the FSM sees `db == 0` in CHORD. `busy` falls on that same edge.
- Release-to-pulse latency: about `DEBOUNCE_CYCLES+2` cycles after the last key's clean release.
- Timeout: fires `HOLD_CYCLES` cycles after entry to CHORD.
- Between successive pulses there is at least `DEBOUNCE_CYCLES+1` cycles of `buttons` = 0.

## Test plan
Run with `DEBOUNCE_CYCLES=4` and `HOLD_CYCLES=20`.
- **Single key:** clean press of key 0 for 10 cycles, then release -> exactly one cycle of `buttons` = 1. `busy` is high from about cycle 6 until the pulse edge. `buttons` = 0 elsewhere.
- **Bounce:** key 1 low 3 cycles, high 2, low 3, then high -> `db` never changes, `busy` stays 0, no pulse.
- **Overlapping chord:** keys 0, 1, 2 pressed at staggered times and released at staggered times, all within 15 cycles -> one pulse of `buttons` = 7 after the last release. A second identical gesture gives a second single 7.
- **All four keys:** press all four simultaneously, then release -> one pulse of `buttons` = 15.
- **Timeout:** hold key 3 for 40 cycles -> no pulse. `busy` stays 1 through WAIT_RELEASE and falls after `db` clears. A later press of key 2 alone gives `buttons` = 4.
- **Reset mid-chord:** assert `reset_n` low with key 0 held in CHORD -> `buttons` = 0 and `busy` = 0 at once. After deassertion with key 0 still held, `busy` rises after debounce, and release gives `buttons` = 1.
